// File: rtl/ifu.sv
// Instruction fetch unit: owns PC/IR, prefetches one word per PC from a
// req/ack instruction memory and computes the next PC for the controller.
module ifu #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWr,
    input  logic        IRWr,
    input  logic [1:0]  NPCOp,
    input  logic        Zero,
    input  logic [31:0] RegA,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        busy
);
    localparam int unsigned W = 32;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   fbuf;
    logic [W-1:0]   npc;
    logic [W-1:0]   br_off;
    logic           ack;

    // An ack only counts while a request is actually being presented.
    assign ack     = imem_ack & imem_req;
    assign PCPlus4 = PC + W'(4);
    assign br_off  = {{14{IR[15]}}, IR[15:0], 2'b00};

    always_comb begin
        npc = PC + W'(4);
        case (NPCOp)
            2'b00: npc = PC + W'(4);
            2'b01: npc = Zero ? (PC + br_off) : PC;
            2'b10: npc = {PC[31:28], IR[25:0], 2'b00};
            2'b11: npc = RegA & ~W'(3);
            default: npc = PC + W'(4);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REQ;
            PC        <= PC_RESET;
            IR        <= '0;
            fbuf      <= '0;
            imem_req  <= 1'b0;
            imem_addr <= PC_RESET;
            busy      <= 1'b1;
        end else begin
            // IR always takes the word belonging to the PC of this cycle.
            if (IRWr) begin
                if (state == HOLD)
                    IR <= fbuf;
                else if (state == REQ && ack)
                    IR <= imem_rdata;
            end

            if (PCWr)
                PC <= npc;

            case (state)
                REQ: begin
                    if (ack) begin
                        if (PCWr) begin
                            imem_req  <= 1'b1;
                            imem_addr <= npc;
                            busy      <= 1'b1;
                        end else begin
                            fbuf     <= imem_rdata;
                            state    <= HOLD;
                            imem_req <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end else if (PCWr && imem_req) begin
                        // Request in flight for the old PC must complete first.
                        state <= DISCARD;
                    end else begin
                        imem_req  <= 1'b1;
                        imem_addr <= PCWr ? npc : PC;
                        busy      <= 1'b1;
                    end
                end
                HOLD: begin
                    if (PCWr) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= npc;
                        busy      <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (ack) begin
                        state     <= REQ;
                        imem_addr <= PCWr ? npc : PC;
                    end
                end
                default: begin
                    state    <= REQ;
                    imem_req <= 1'b0;
                    busy     <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed NPC table, hand-written fetch corner cases and a
// randomized run against a transaction-level reference model.
module tb_ifu;
    logic        clk = 1'b0;
    logic        rst;
    logic        PCWr, IRWr, Zero, imem_ack, imem_req, busy;
    logic [1:0]  NPCOp;
    logic [31:0] RegA, imem_addr, imem_rdata, IR, PC, PCPlus4;

    int checks = 0;
    int errors = 0;

    ifu #(.PC_RESET(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .PCWr(PCWr), .IRWr(IRWr), .NPCOp(NPCOp),
        .Zero(Zero), .RegA(RegA), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IR(IR), .PC(PC),
        .PCPlus4(PCPlus4), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [1:0]  op;
        logic        zero;
        logic [31:0] rega;
        logic [31:0] exp_pc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        PCWr = 0; IRWr = 0; NPCOp = 2'b00; Zero = 0; RegA = '0;
        imem_ack = 0; imem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", PC, 32'h3000);
        chk("rst_ir", IR, 32'h0);
        chk("rst_busy", 32'(busy), 32'd1);
        rst = 0;
    endtask

    // Hold the request for lat cycles, then ack with w; address checked every cycle.
    task automatic fetch_word(input logic [31:0] w, input int lat, input logic [31:0] addr);
        for (int i = 0; i < lat; i++) begin
            chk("fetch_req_wait", 32'(imem_req), 32'd1);
            chk("fetch_addr_wait", imem_addr, addr);
            tick();
        end
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, addr);
        imem_ack = 1; imem_rdata = w;
        tick();
        imem_ack = 0;
        chk("fetch_busy_low", 32'(busy), 32'd0);
        chk("fetch_req_low", 32'(imem_req), 32'd0);
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [31:0] ir,
                                            input logic [1:0] op, input logic z,
                                            input logic [31:0] rega);
        logic signed [15:0] imm;
        logic [31:0] off;
        imm = ir[15:0];
        off = 32'(imm);
        case (op)
            2'd0: return pc + 32'd4;
            2'd1: return z ? pc + off * 32'd4 : pc;
            2'd2: return (pc & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
            default: return rega & 32'hFFFF_FFFC;
        endcase
    endfunction

    vec_t vecs[9];

    // Random-phase model state.
    logic [31:0] pc_m, ir_m, buf_m, npc_m, prev_addr;
    logic        avail, stale, first, prev_pend;
    int          wait_cnt, lat;

    initial begin
        vecs[0] = '{32'h0000_0021, 2'd0, 1'b0, 32'h0,         32'h0000_3004};
        vecs[1] = '{32'h1000_FFFE, 2'd1, 1'b1, 32'h0,         32'h0000_2FF8};
        vecs[2] = '{32'h1000_FFFE, 2'd1, 1'b0, 32'h0,         32'h0000_3000};
        vecs[3] = '{32'h1000_0010, 2'd1, 1'b1, 32'h0,         32'h0000_3040};
        vecs[4] = '{32'h1000_8000, 2'd1, 1'b1, 32'h0,         32'hFFFE_3000};
        vecs[5] = '{32'h0F00_0000, 2'd2, 1'b0, 32'h0,         32'h0C00_0000};
        vecs[6] = '{32'h03FF_FFFF, 2'd2, 1'b1, 32'h0,         32'h0FFF_FFFC};
        vecs[7] = '{32'h0000_0000, 2'd3, 1'b0, 32'h0000_3017, 32'h0000_3014};
        vecs[8] = '{32'h1234_5678, 2'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC};

        // NPC selection table, each from a fresh fetch at 0x3000.
        for (int v = 0; v < 9; v++) begin
            do_reset();
            tick();
            fetch_word(vecs[v].ir, 0, 32'h3000);
            IRWr = 1; tick(); IRWr = 0;
            chk("vec_ir", IR, vecs[v].ir);
            NPCOp = vecs[v].op; Zero = vecs[v].zero; RegA = vecs[v].rega; PCWr = 1;
            tick();
            clear_inputs();
            chk("vec_pc", PC, vecs[v].exp_pc);
            chk("vec_busy", 32'(busy), 32'd1);
            chk("vec_addr", imem_addr, vecs[v].exp_pc);
            chk("vec_pc4", PCPlus4, vecs[v].exp_pc + 32'd4);
        end

        // Basic fetch with 2-cycle ack latency.
        do_reset();
        tick();
        fetch_word(32'h0000_0021, 2, 32'h3000);
        IRWr = 1; tick(); IRWr = 0;
        chk("basic_ir", IR, 32'h21);
        PCWr = 1; tick(); PCWr = 0;
        chk("basic_pc", PC, 32'h3004);
        chk("basic_addr", imem_addr, 32'h3004);
        chk("basic_req", 32'(imem_req), 32'd1);

        // Branch from 0x3004, taken then not taken.
        fetch_word(32'h1000_FFFE, 0, 32'h3004);
        IRWr = 1; tick(); IRWr = 0;
        NPCOp = 2'd1; Zero = 1; PCWr = 1; tick(); PCWr = 0;
        chk("br_taken_pc", PC, 32'h2FFC);
        fetch_word(32'h1000_FFFE, 0, 32'h2FFC);
        Zero = 0; PCWr = 1; tick(); clear_inputs();
        chk("br_not_taken_pc", PC, 32'h2FFC);

        // PCWr while a request is outstanding: stale data must be dropped.
        do_reset();
        tick();
        fetch_word(32'h0000_0021, 0, 32'h3000);
        IRWr = 1; tick(); IRWr = 0;
        PCWr = 1; tick();
        chk("stale_start_addr", imem_addr, 32'h3004);
        tick(); PCWr = 0; IRWr = 1;
        chk("stale_pc", PC, 32'h3008);
        for (int i = 0; i < 2; i++) begin
            chk("stale_addr_hold", imem_addr, 32'h3004);
            chk("stale_req_hold", 32'(imem_req), 32'd1);
            tick();
            chk("stale_ir", IR, 32'h21);
            chk("stale_busy", 32'(busy), 32'd1);
        end
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; tick(); clear_inputs();
        chk("stale_ir_after_ack", IR, 32'h21);
        chk("stale_busy_after_ack", 32'(busy), 32'd1);
        fetch_word(32'h1234_5678, 1, 32'h3008);
        IRWr = 1; tick(); IRWr = 0;
        chk("refetch_ir", IR, 32'h1234_5678);

        // IRWr + PCWr + ack in the same REQ cycle.
        PCWr = 1; tick(); PCWr = 0;
        chk("sim_pre_addr", imem_addr, 32'h300C);
        IRWr = 1; PCWr = 1; imem_ack = 1; imem_rdata = 32'hCAFE_F00D;
        tick(); clear_inputs();
        chk("sim_ir", IR, 32'hCAFE_F00D);
        chk("sim_pc", PC, 32'h3010);
        chk("sim_busy", 32'(busy), 32'd1);
        chk("sim_req", 32'(imem_req), 32'd1);
        chk("sim_addr", imem_addr, 32'h3010);

        // Asynchronous reset in the middle of a request.
        rst = 1; #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_pc", PC, 32'h3000);
        chk("async_ir", IR, 32'h0);
        chk("async_busy", 32'(busy), 32'd1);
        tick(); rst = 0;
        tick();
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr, 32'h3000);

        // Randomized run against the reference model.
        do_reset();
        pc_m = 32'h3000; ir_m = '0; buf_m = '0; avail = 0; stale = 0; first = 1;
        prev_pend = 0; prev_addr = '0; wait_cnt = 0; lat = $urandom_range(0, 3);
        for (int c = 0; c < 3000; c++) begin
            logic pcwr_r, irwr_r, ack_r, req_m;
            logic [31:0] n_ir;
            req_m = !avail && !first;
            chk("rnd_pc", PC, pc_m);
            chk("rnd_ir", IR, ir_m);
            chk("rnd_busy", 32'(busy), 32'(!avail));
            chk("rnd_req", 32'(imem_req), 32'(req_m));
            chk("rnd_pc4", PCPlus4, pc_m + 32'd4);
            if (req_m && !stale) chk("rnd_addr", imem_addr, pc_m);
            if (prev_pend) begin
                chk("rnd_req_held", 32'(imem_req), 32'd1);
                chk("rnd_addr_held", imem_addr, prev_addr);
            end

            pcwr_r = ($urandom_range(0, 99) < 25);
            irwr_r = ($urandom_range(0, 99) < 50);
            PCWr = pcwr_r; IRWr = irwr_r;
            NPCOp = 2'($urandom_range(0, 3));
            Zero = 1'($urandom_range(0, 1));
            RegA = $urandom;
            ack_r = 0;
            if (imem_req) begin
                if (wait_cnt >= lat) begin
                    ack_r = 1;
                    wait_cnt = 0;
                    lat = $urandom_range(0, 3);
                end else begin
                    wait_cnt++;
                end
            end
            imem_ack = ack_r;
            imem_rdata = ack_r ? memfn(imem_addr) : $urandom;
            prev_pend = imem_req && !ack_r;
            prev_addr = imem_addr;

            npc_m = ref_npc(pc_m, ir_m, NPCOp, Zero, RegA);
            n_ir = ir_m;
            if (irwr_r) begin
                if (avail) n_ir = buf_m;
                else if (ack_r && !stale) n_ir = memfn(pc_m);
            end
            tick();
            ir_m = n_ir;
            if (ack_r && !stale && !pcwr_r) begin
                avail = 1;
                buf_m = memfn(pc_m);
            end
            if (pcwr_r) begin
                stale = req_m && !ack_r;
                pc_m = npc_m;
                avail = 0;
            end else if (ack_r) begin
                stale = 0;
            end
            first = 0;
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifu.md
Name: ifu

Overview:
Instruction fetch unit that sits directly upstream of the multicycle controller. It owns the PC and IR registers and fetches instruction words from a variable-latency instruction memory with a req/ack handshake. It computes the next PC from the controller's NPCOp/Zero, and loads IR when the controller asserts IRWr. A busy output tells the controller that the prefetched word is not yet available.

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset (first fetch address)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
PCWr  input  1  from controller: load PC with NPC this edge
IRWr  input  1  from controller: load IR from fetch buffer this edge
NPCOp  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 register
Zero  input  1  ALU zero flag, qualifies branch
RegA  input  32  register operand for jr target
imem_req  output  1  fetch request, held high until imem_ack
imem_addr  output  32  fetch address, stable while imem_req high
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word, valid when imem_ack
IR  output  32  instruction register
PC  output  32  program counter
PCPlus4  output  32  PC+4, combinational (link value)
busy  output  1  high when fetch buffer holds no valid word for the current PC

Behaviour:
- Reset values: PC=PC_RESET, IR=0, fetch buffer invalid, state REQ, imem_req=0 while rst high, busy=1.
- NPC (combinational, 32-bit, wraps modulo 2^32):
  - 00: PC+4.
  - 01: Zero ? PC + (sext(IR[15:0])<<2) : PC. The controller has already advanced PC past the branch.
  - 10: {PC[31:28], IR[25:0], 2'b00}.
  - 11: {RegA[31:2], 2'b00}. Low bits are forced to zero.
- FSM states: REQ, HOLD, DISCARD.
  - REQ: imem_req=1, imem_addr=PC. On imem_ack: capture imem_rdata into the buffer and set valid. Go to HOLD.
  - HOLD: imem_req=0, buffer valid, busy=0.
  - DISCARD: imem_req=1, imem_addr=the PC held at request start. This is a request still outstanding for a stale PC. On imem_ack: drop the data and go to REQ.
- imem_req must never drop and imem_addr must never change before imem_ack. The address is latched at request start.
- PCWr:
  - PC<=NPC.
  - Buffer invalidated.
  - In HOLD, go to REQ. The new request starts next cycle, with addr = new PC.
  - In REQ without ack in the same cycle, go to DISCARD.
  - In REQ with ack in the same cycle, drop the data and go to REQ for the new PC.
  - In DISCARD, stay in DISCARD.
- IRWr:
  - If buffer valid (HOLD): IR<=buffer; the buffer stays valid (IR reloads are idempotent).
  - If busy: ignored, IR unchanged. The controller is responsible for stalling.
  - Same-cycle capture: IRWr together with imem_ack in REQ (no PCWr) loads IR directly from imem_rdata.
- IRWr and PCWr in the same cycle: IR takes the word for the old PC, then the PC update proceeds as above.
- busy = ~buffer_valid, registered state only.
- Mid-operation reset: the outstanding request is abandoned immediately, imem_req=0, and all registers return to reset values.
- Fetch latency: imem_ack earliest the same cycle as req gives busy low the next cycle. Zero-wait-state memory gives a 1-cycle bubble after each PCWr.

Test Plan:
- Reset then ack after 2 cycles with rdata=32'h00000021 -> imem_addr=0x3000 held for 3 cycles; busy falls; IRWr gives IR=0x00000021. PCWr with NPCOp=00 gives PC=0x3004 and imem_addr=0x3004.
- Branch taken: PC=0x3004, IR=32'h1000FFFE, Zero=1, NPCOp=01, PCWr -> PC=0x2FFC. Repeat with Zero=0 -> PC stays 0x3004.
- Jump: PC=0x3008, IR=32'h0F000000, NPCOp=10 -> PC=0x0C000000. jr with RegA=0x00003017 and NPCOp=11 -> PC=0x3014.
- PCWr while a request is outstanding for 0x3004 (ack delayed 3 cycles, rdata=DEADBEEF) -> addr stays 0x3004 until ack. DEADBEEF is never loaded into IR, then a new request for the new PC is issued. IRWr during this period leaves IR unchanged.
- Simultaneous IRWr, PCWr and imem_ack in REQ -> IR=rdata and PC=NPC. The next request addresses the new PC and busy=1.
- Assert rst mid-request -> imem_req=0 asynchronously, PC=0x3000, IR=0. After release, the fetch restarts at 0x3000.
